// File: rtl/cv_loader_pkg.sv
// Shared constants, state type and header test for the cartridge loader.
package cv_loader_pkg;

  localparam logic [15:0] HDR_A = 16'hAA55;
  localparam logic [15:0] HDR_B = 16'h55AA;
  localparam int SG_EXT_PAGE = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } ldr_state_t;

  function automatic logic is_hdr(input logic [15:0] w);
    return (w == HDR_A) || (w == HDR_B);
  endfunction

endpackage

// File: rtl/cv_ldr_fifo.sv
// Show-ahead synchronous FIFO buffering {addr,data} writes.
module cv_ldr_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic         last_o,
  output logic [W-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_q, wr_d;
  logic [PW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) &&
                   (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign last_o  = ((wr_q - rd_q) == (PW+1)'(1));
  assign head_o  = mem_q[rd_q[PW-1:0]];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    // a full FIFO still takes a write when the head leaves this cycle
    if (push_i && (!full_o || pop_i)) begin
      mem_d[wr_q[PW-1:0]] = din_i;
      wr_d = wr_q + 1'b1;
    end
    if (pop_i && !empty_o) begin
      rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cv_cart_loader.sv
// ioctl-to-SDRAM cartridge loader: write buffer, metadata
// extraction and console reset request.
module cv_cart_loader
  import cv_loader_pkg::*;
#(
  parameter int         AW         = 25,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [4:0] SG_INDEX   = 5'd2
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          ioctl_download_i,
  input  logic [7:0]    ioctl_index_i,
  input  logic          ioctl_wr_i,
  input  logic [AW-1:0] ioctl_addr_i,
  input  logic [7:0]    ioctl_dout_i,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_din_o,
  input  logic          mem_ready_i,
  output logic [5:0]    cart_pages_o,
  output logic          sg1000_o,
  output logic          extram_o,
  output logic          header_ok_o,
  output logic          overflow_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          cons_reset_o
);

  ldr_state_t state_q, state_d;
  logic       dl_prev_q;
  logic [5:0] pages_q, pages_d;
  logic       sg_q, sg_d;
  logic       ext_q, ext_d;
  logic       ext_seen_q, ext_seen_d;
  logic       hdr_q, hdr_d;
  logic       ovf_q, ovf_d;
  logic [7:0] byte0_q, byte0_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       cons_q, cons_d;

  logic          wr_ok, push, pop, drop, drained;
  logic          full, empty, last;
  logic [AW+7:0] head;

  cv_ldr_fifo #(
    .W    (AW + 8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .push_i   (push),
    .pop_i    (pop),
    .din_i    ({ioctl_addr_i, ioctl_dout_i}),
    .full_o   (full),
    .empty_o  (empty),
    .last_o   (last),
    .head_o   (head)
  );

  assign wr_ok   = (state_q == LOAD) && ioctl_wr_i;
  assign pop     = !empty && mem_ready_i;
  assign push    = wr_ok && (!full || pop);
  assign drop    = wr_ok && full && !pop;
  // FIFO will be empty after this edge
  assign drained = !push && (empty || (last && pop));

  always_comb begin
    state_d    = state_q;
    pages_d    = pages_q;
    sg_d       = sg_q;
    ext_d      = ext_q;
    ext_seen_d = ext_seen_q;
    hdr_d      = hdr_q;
    ovf_d      = ovf_q;
    byte0_d    = byte0_q;

    unique case (state_q)
      IDLE: begin
        if (ioctl_download_i && !dl_prev_q) begin
          state_d    = LOAD;
          pages_d    = '0;
          ext_d      = 1'b0;
          ext_seen_d = 1'b0;
          hdr_d      = 1'b0;
          ovf_d      = 1'b0;
          sg_d       = (ioctl_index_i[4:0] == SG_INDEX);
        end
      end
      LOAD: begin
        if (!ioctl_download_i) begin
          state_d = drained ? DONE : FLUSH;
        end
      end
      FLUSH: begin
        if (drained) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (drop) begin
      ovf_d = 1'b1;
    end

    if (push) begin
      if (ioctl_addr_i[19:14] > pages_q) begin
        pages_d = ioctl_addr_i[19:14];
      end
      if (ioctl_addr_i == '0) begin
        byte0_d = ioctl_dout_i;
      end
      if (ioctl_addr_i == AW'(1)) begin
        hdr_d = is_hdr({byte0_q, ioctl_dout_i});
      end
      if (sg_q && (ioctl_addr_i[AW-1:13] ==
                   (AW-13)'(SG_EXT_PAGE))) begin
        ext_seen_d = 1'b1;
        ext_d = (ioctl_dout_i == 8'hFF) &&
                (ext_q || !ext_seen_q);
      end
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    cons_d = busy_d;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      dl_prev_q  <= 1'b1;
      pages_q    <= '0;
      sg_q       <= 1'b0;
      ext_q      <= 1'b0;
      ext_seen_q <= 1'b0;
      hdr_q      <= 1'b0;
      ovf_q      <= 1'b0;
      byte0_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cons_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dl_prev_q  <= ioctl_download_i;
      pages_q    <= pages_d;
      sg_q       <= sg_d;
      ext_q      <= ext_d;
      ext_seen_q <= ext_seen_d;
      hdr_q      <= hdr_d;
      ovf_q      <= ovf_d;
      byte0_q    <= byte0_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cons_q     <= cons_d;
    end
  end

  assign mem_we_o     = !empty;
  assign mem_addr_o   = empty ? '0 : head[AW+7:8];
  assign mem_din_o    = empty ? '0 : head[7:0];
  assign cart_pages_o = pages_q;
  assign sg1000_o     = sg_q;
  assign extram_o     = ext_q;
  assign header_ok_o  = hdr_q;
  assign overflow_o   = ovf_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign cons_reset_o = cons_q;

endmodule

// File: tb/tb_cv_cart_loader.sv
// Directed bench for cv_cart_loader: cycle table plus
// streaming, flush and reset sequences.
module tb_cv_cart_loader;

  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          reset_n, dl, wr, rdy;
  logic [7:0]    idx, dout;
  logic [AW-1:0] addr;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [5:0]    pages;
  logic          sg, ext, hdr, ovf, busy, done, cons;

  always #5 clk = ~clk;

  cv_cart_loader #(
    .AW(AW), .FIFO_DEPTH(4), .SG_INDEX(5'd2)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .ioctl_download_i(dl),
    .ioctl_index_i   (idx),
    .ioctl_wr_i      (wr),
    .ioctl_addr_i    (addr),
    .ioctl_dout_i    (dout),
    .mem_we_o        (mem_we),
    .mem_addr_o      (mem_addr),
    .mem_din_o       (mem_din),
    .mem_ready_i     (rdy),
    .cart_pages_o    (pages),
    .sg1000_o        (sg),
    .extram_o        (ext),
    .header_ok_o     (hdr),
    .overflow_o      (ovf),
    .busy_o          (busy),
    .done_o          (done),
    .cons_reset_o    (cons)
  );

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  logic mon_en = 1'b0;
  logic [AW+7:0] expq [$];

  typedef struct {
    logic          dl;
    logic          wr;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic          rdy;
    int            rep;
    logic [AW+7:0] e_head;
    logic          e_we;
    logic          e_busy;
    logic          e_done;
    logic          e_hdr;
    logic          e_ovf;
  } vec_t;

  vec_t tv [14];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(
    input logic we, input logic [AW+7:0] h, input logic bz,
    input logic dn, input logic cr, input logic hd, input logic ov,
    input logic s, input logic e, input logic [5:0] p);
    return 64'({we, h, bz, dn, cr, hd, ov, s, e, p});
  endfunction

  function automatic logic [63:0] outs();
    return pk(mem_we, {mem_addr, mem_din}, busy, done, cons,
              hdr, ovf, sg, ext, pages);
  endfunction

  // scoreboard the mem port just before each edge, then advance
  task automatic tick();
    if (mem_we && rdy) begin
      acc_cnt++;
      if (mon_en) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mem_extra got=%0h exp=none",
                   {mem_addr, mem_din});
        end else begin
          chk("mem_seq", 64'({mem_addr, mem_din}), 64'(expq.pop_front()));
        end
      end
    end
    @(posedge clk);
    #1;
    if (done) done_cnt++;
  endtask

  function automatic logic [7:0] gen(input int a, input bit sgff,
                                     input int bad_a);
    logic [31:0] av;
    av = a;
    if (a == bad_a) return 8'h12;
    if (a == 0) return 8'hAA;
    if (a == 1) return 8'h55;
    if (sgff && a >= 32'h2000 && a <= 32'h3FFF) return 8'hFF;
    return av[7:0] ^ av[15:8] ^ 8'h3C;
  endfunction

  task automatic run_load(input logic [7:0] ix, input int n,
                          input int step, input bit sgff,
                          input int bad_a);
    int a;
    mon_en = 1'b1;
    rdy = 1'b1;
    idx = ix;
    wr = 1'b0;
    dl = 1'b0;
    tick();
    dl = 1'b1;
    tick();
    done_cnt = 0;
    for (int i = 0; i < n; i++) begin
      a = i * step;
      wr = 1'b1;
      addr = AW'(a);
      dout = gen(a, sgff, bad_a);
      expq.push_back({addr, dout});
      tick();
    end
    wr = 1'b0;
    dl = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("q_drained", 64'(expq.size()), 64'd0);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("busy_end", 64'({busy, cons}), 64'd0);
    chk("no_ovf", 64'(ovf), 64'd0);
    mon_en = 1'b0;
  endtask

  initial begin
    int last_acc, done_at;
    logic busy_drop;

    tv[0]  = '{0, 0, 0, 8'h00, 0, 1,  '0,               0, 0, 0, 0, 0};
    tv[1]  = '{1, 0, 0, 8'h00, 0, 1,  '0,               0, 1, 0, 0, 0};
    tv[2]  = '{1, 1, 0, 8'hAA, 0, 1,  {25'd0, 8'hAA},   1, 1, 0, 0, 0};
    tv[3]  = '{1, 1, 1, 8'h55, 0, 1,  {25'd0, 8'hAA},   1, 1, 0, 1, 0};
    tv[4]  = '{1, 1, 2, 8'h11, 0, 1,  {25'd0, 8'hAA},   1, 1, 0, 1, 0};
    tv[5]  = '{1, 1, 3, 8'h22, 0, 1,  {25'd0, 8'hAA},   1, 1, 0, 1, 0};
    tv[6]  = '{1, 1, 4, 8'h33, 0, 1,  {25'd0, 8'hAA},   1, 1, 0, 1, 1};
    tv[7]  = '{1, 0, 0, 8'h00, 0, 15, {25'd0, 8'hAA},   1, 1, 0, 1, 1};
    tv[8]  = '{1, 0, 0, 8'h00, 1, 1,  {25'd1, 8'h55},   1, 1, 0, 1, 1};
    tv[9]  = '{1, 0, 0, 8'h00, 1, 1,  {25'd2, 8'h11},   1, 1, 0, 1, 1};
    tv[10] = '{1, 0, 0, 8'h00, 1, 1,  {25'd3, 8'h22},   1, 1, 0, 1, 1};
    tv[11] = '{1, 0, 0, 8'h00, 1, 1,  '0,               0, 1, 0, 1, 1};
    tv[12] = '{0, 0, 0, 8'h00, 1, 1,  '0,               0, 1, 1, 1, 1};
    tv[13] = '{0, 0, 0, 8'h00, 0, 1,  '0,               0, 0, 0, 1, 1};

    reset_n = 1'b0;
    dl = 1'b0;
    wr = 1'b0;
    rdy = 1'b0;
    idx = 8'h00;
    addr = '0;
    dout = 8'h00;
    tick();
    tick();
    chk("reset_state", outs(), 64'd0);
    reset_n = 1'b1;

    // backpressure and overflow table
    acc_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      dl = tv[i].dl;
      wr = tv[i].wr;
      addr = tv[i].a;
      dout = tv[i].d;
      rdy = tv[i].rdy;
      for (int r = 0; r < tv[i].rep; r++) begin
        tick();
        chk($sformatf("vec%0d", i), outs(),
            pk(tv[i].e_we, tv[i].e_head, tv[i].e_busy, tv[i].e_done,
               tv[i].e_busy, tv[i].e_hdr, tv[i].e_ovf, 1'b0, 1'b0,
               6'd0));
      end
    end
    chk("bp_writes", 64'(acc_cnt), 64'd4);

    run_load(8'h00, 16384, 1, 1'b0, -1);
    chk("coleco_meta", 64'({hdr, sg, ext, pages}), 64'({1'b1, 1'b0, 1'b0, 6'd0}));

    run_load(8'h02, 16384, 1, 1'b1, -1);
    chk("sg_ext_ff", 64'({sg, ext, pages}), 64'({1'b1, 1'b1, 6'd0}));

    run_load(8'h22, 16384, 1, 1'b1, 32'h2A00);
    chk("sg_ext_bad", 64'({sg, ext, pages}), 64'({1'b1, 1'b0, 6'd0}));

    run_load(8'h00, 32, 32'h4000, 1'b0, -1);
    chk("pages_512k", 64'({hdr, sg, ext, pages}), 64'({1'b0, 1'b0, 1'b0, 6'd31}));

    run_load(8'h00, 64, 256, 1'b0, -1);
    chk("pages_16k", 64'(pages), 64'd0);

    // flush with three entries queued and ready toggling
    mon_en = 1'b1;
    rdy = 1'b0;
    idx = 8'h00;
    dl = 1'b0;
    tick();
    dl = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      wr = 1'b1;
      addr = AW'(32'h10 + k);
      dout = 8'(8'hC0 + k);
      expq.push_back({addr, dout});
      tick();
    end
    wr = 1'b0;
    acc_cnt = 0;
    done_cnt = 0;
    last_acc = -1;
    done_at = -1;
    busy_drop = 1'b0;
    for (int i = 0; i < 12; i++) begin
      dl = 1'b0;
      rdy = (i % 2 == 0);
      if (mem_we && rdy) last_acc = i;
      tick();
      if (done && done_at < 0) done_at = i;
      if (done_at < 0 && !busy) busy_drop = 1'b1;
    end
    chk("flush_done_at", 64'(done_at), 64'd4);
    chk("flush_last_acc", 64'(last_acc), 64'd4);
    chk("flush_accepts", 64'(acc_cnt), 64'd3);
    chk("flush_done_cnt", 64'(done_cnt), 64'd1);
    chk("flush_busy_held", 64'(busy_drop), 64'd0);
    chk("flush_q", 64'(expq.size()), 64'd0);
    mon_en = 1'b0;

    // reset in the middle of a load
    rdy = 1'b0;
    idx = 8'h02;
    dl = 1'b0;
    tick();
    dl = 1'b1;
    tick();
    wr = 1'b1;
    addr = '0;
    dout = 8'hAA;
    tick();
    addr = AW'(1);
    dout = 8'h55;
    tick();
    addr = AW'(32'h8000);
    dout = 8'h07;
    tick();
    wr = 1'b0;
    chk("rst_pre", outs(),
        pk(1'b1, {25'd0, 8'hAA}, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
           1'b0, 6'd2));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst_outs", outs(), 64'd0);
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1;
      addr = AW'(5);
      tick();
      chk($sformatf("rst_hold%0d", i), 64'({busy, mem_we}), 64'd0);
    end
    wr = 1'b0;
    dl = 1'b0;
    tick();
    dl = 1'b1;
    tick();
    chk("rst_reenter", 64'({busy, cons}), 64'b11);
    wr = 1'b1;
    addr = AW'(9);
    dout = 8'h01;
    tick();
    wr = 1'b0;
    chk("rst_push", 64'({mem_we, mem_addr, mem_din}), 64'({1'b1, 25'd9, 8'h01}));
    dl = 1'b0;
    rdy = 1'b1;
    for (int i = 0; i < 10 && busy; i++) tick();
    chk("rst_final_idle", 64'({busy, mem_we}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
